hwce_y_out_serializer: RTL



---
 rtl/hwce_y_out_serializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hwce_y_out_serializer.sv
// HWCE output serializer: FIFO of NPX-pixel vectors, one pixel per beat out.
// Ports: clk/rst/clear, tile_len, y_in/valid_y_in/ready_in, y_out/valid_y_out/ready_out,
// y_last, tile_done, max_occ (high-watermark, only with HWCE_OUT_FIFO_STATS_EN).
module hwce_y_out_serializer #(
  parameter int CONV_WIDTH = 16,
  parameter int NPX        = 2,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [CNT_WIDTH-1:0]        tile_len,
  input  logic [NPX*CONV_WIDTH-1:0]   y_in,
  input  logic                        valid_y_in,
  output logic                        ready_in,
  output logic [CONV_WIDTH-1:0]       y_out,
  output logic                        valid_y_out,
  input  logic                        ready_out,
  output logic                        y_last,
  output logic                        tile_done,
  output logic [$clog2(DEPTH):0]      max_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NPX > 1) ? $clog2(NPX) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(NPX - 1);

  logic [NPX*CONV_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             rptr;
  logic [CW-1:0]             count;
  logic [IW-1:0]             idx;
  logic [CNT_WIDTH-1:0]      tcnt;
  logic                      done_q;

  logic [NPX*CONV_WIDTH-1:0] head;
  logic [CONV_WIDTH-1:0]     pix [NPX];
  logic [CNT_WIDTH-1:0]      tl_m1;
  logic                      push;
  logic                      beat;
  logic                      pop;
  logic                      last;

  assign ready_in    = (count < FULL);
  assign valid_y_out = (count != '0);
  assign push        = valid_y_in & ready_in;
  assign beat        = valid_y_out & ready_out;

  assign head = mem[rptr];

  for (genvar p = 0; p < NPX; p++) begin : g_pix
    assign pix[p] = head[p*CONV_WIDTH +: CONV_WIDTH];
  end

  assign y_out = valid_y_out ? pix[idx] : '0;

  // tile_len == 0 means an unbounded tile
  assign tl_m1 = tile_len - CNT_WIDTH'(1);
  assign last  = valid_y_out
               & (tile_len != '0)
               & (tcnt == tl_m1);

  assign y_last    = last;
  assign tile_done = done_q;

  // a y_last beat pops even mid-vector, dropping the rest
  assign pop = beat & ((idx == IDX_LAST) | last);

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wptr] <= y_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      idx    <= '0;
      tcnt   <= '0;
      done_q <= 1'b0;
    end else if (clear) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      idx    <= '0;
      tcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (beat) begin
        idx  <= pop ? '0 : idx + IW'(1);
        tcnt <= last ? '0 : tcnt + CNT_WIDTH'(1);
      end
      done_q <= beat & last;
    end
  end

`ifdef HWCE_OUT_FIFO_STATS_EN
  logic [CW-1:0] max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
    end else if (clear) begin
      max_q <= '0;
    end else if (count > max_q) begin
      max_q <= count;
    end
  end

  assign max_occ = max_q;
`else
  assign max_occ = '0;
`endif

endmodule
